debounce_multi: RTL

- Parametrised successor to the single-switch debouncer. Filters N_CH independent asynchronous switch/button inputs.
- Each channel has its own synchroniser, its own settle counter, and a true-filter state machine.
  - A candidate level must hold continuously for a run-time-programmable period before it is accepted.
  - A glitch cancels the pending change; it does not merely blank the output.
- Produces debounced levels plus one-cycle rise/fall pulses for the robotics cape button/limit-switch logic.

---
 rtl/debounce_multi.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, settle counter and
// true-filter FSM. Optional long-press detection via DEBOUNCE_LONG_PRESS_EN.
module debounce_multi #(
   parameter int unsigned      N_CH        = 4,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      COUNT_W     = 16,
   parameter logic [N_CH-1:0]  INIT_VAL    = '0
`ifdef DEBOUNCE_LONG_PRESS_EN
   ,
   parameter int unsigned      LONG_W      = 24
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_CH-1:0]     switch_in,
   input  logic [COUNT_W-1:0]  hold_limit,
`ifdef DEBOUNCE_LONG_PRESS_EN
   input  logic [LONG_W-1:0]   long_limit,
   output logic [N_CH-1:0]     long_press,
`endif
   output logic [N_CH-1:0]     switch_out,
   output logic [N_CH-1:0]     rise,
   output logic [N_CH-1:0]     fall
);

   typedef enum logic {STABLE, SETTLING} state_e;

   logic [SYNC_STAGES-1:0] sync_q  [N_CH];
   logic [SYNC_STAGES-1:0] sync_d  [N_CH];
   state_e                 state_q [N_CH];
   state_e                 state_d [N_CH];
   logic [COUNT_W-1:0]     cnt_q   [N_CH];
   logic [COUNT_W-1:0]     cnt_d   [N_CH];
   logic [N_CH-1:0]        switch_out_q, switch_out_d;
   logic [N_CH-1:0]        rise_q, rise_d;
   logic [N_CH-1:0]        fall_q, fall_d;
   logic [N_CH-1:0]        s;

`ifdef DEBOUNCE_LONG_PRESS_EN
   logic [LONG_W-1:0]      lp_cnt_q [N_CH];
   logic [LONG_W-1:0]      lp_cnt_d [N_CH];
   logic [N_CH-1:0]        long_press_q, long_press_d;
`endif

   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         s[i]      = sync_q[i][SYNC_STAGES-1];
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], switch_in[i]};
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         state_d[i]      = state_q[i];
         cnt_d[i]        = cnt_q[i];
         switch_out_d[i] = switch_out_q[i];
         rise_d[i]       = 1'b0;
         fall_d[i]       = 1'b0;
         case (state_q[i])
            STABLE: begin
               if (s[i] != switch_out_q[i]) begin
                  cnt_d[i]   = hold_limit;
                  state_d[i] = SETTLING;
               end
            end
            SETTLING: begin
               // Any return to the accepted level cancels the pending change.
               if (s[i] == switch_out_q[i]) begin
                  state_d[i] = STABLE;
               end else if (cnt_q[i] == '0) begin
                  switch_out_d[i] = s[i];
                  rise_d[i]       = s[i];
                  fall_d[i]       = ~s[i];
                  state_d[i]      = STABLE;
               end else begin
                  cnt_d[i] = cnt_q[i] - COUNT_W'(1);
               end
            end
            default: state_d[i] = STABLE;
         endcase
      end
   end

`ifdef DEBOUNCE_LONG_PRESS_EN
   // Counter is zero on the rise edge itself, so the pulse lands long_limit
   // cycles after rise; saturation keeps it from re-firing until a fall.
   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         lp_cnt_d[i]     = lp_cnt_q[i];
         long_press_d[i] = 1'b0;
         if (!switch_out_d[i] || rise_d[i]) begin
            lp_cnt_d[i]     = '0;
            long_press_d[i] = rise_d[i] && (long_limit == '0);
         end else if (lp_cnt_q[i] < long_limit) begin
            lp_cnt_d[i]     = lp_cnt_q[i] + LONG_W'(1);
            long_press_d[i] = (lp_cnt_d[i] == long_limit);
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            sync_q[i]  <= {SYNC_STAGES{INIT_VAL[i]}};
            state_q[i] <= STABLE;
            cnt_q[i]   <= '0;
`ifdef DEBOUNCE_LONG_PRESS_EN
            lp_cnt_q[i] <= '0;
`endif
         end
         switch_out_q <= INIT_VAL;
         rise_q       <= '0;
         fall_q       <= '0;
`ifdef DEBOUNCE_LONG_PRESS_EN
         long_press_q <= '0;
`endif
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            sync_q[i]  <= sync_d[i];
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
`ifdef DEBOUNCE_LONG_PRESS_EN
            lp_cnt_q[i] <= lp_cnt_d[i];
`endif
         end
         switch_out_q <= switch_out_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
`ifdef DEBOUNCE_LONG_PRESS_EN
         long_press_q <= long_press_d;
`endif
      end
   end

   assign switch_out = switch_out_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
   assign long_press = long_press_q;
`endif

endmodule
